// File: rtl/seq_arith_unit.sv
// seq_arith_unit: WIDTH-bit unsigned add / subtract / multiply behind a
// start/done handshake. Add and subtract finish in one cycle. Multiply is an
// iterative shift-add over WIDTH clock edges, so no array multiplier is built.
//
//   state | meaning
//   IDLE  | waiting for start
//   MUL   | shift-add iterations running, busy=1, start ignored
//   DONE  | result/err valid, done=1; start here is accepted back-to-back
module seq_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 err_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;

  logic [2*WIDTH-1:0]   add_d;
  logic [2*WIDTH-1:0]   sub_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [CW-1:0]        cnt_d;
  logic                 last_iter_d;

  // Single-cycle results and the next shift-add step of the multiplier.
  // The sub is done one bit wider so bit WIDTH falls out as the borrow.
  always_comb begin
    add_d            = '0;
    sub_d            = '0;
    add_d[WIDTH:0]   = {1'b0, A} + {1'b0, B};
    sub_d[WIDTH:0]   = {1'b0, A} - {1'b0, B};
    acc_d            = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    cnt_d            = cnt_q + CW'(1);
    last_iter_d      = (cnt_d == CW'(WIDTH));
  end

  // Control FSM and datapath registers; reset takes priority and aborts a
  // multiply in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            case (op)
              OP_ADD: begin
                result_q <= add_d;
                err_q    <= 1'b0;
                state_q  <= DONE;
              end
              OP_SUB: begin
                result_q <= sub_d;
                err_q    <= 1'b0;
                state_q  <= DONE;
              end
              OP_MUL: begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, A};
                mplier_q <= B;
                cnt_q    <= '0;
                state_q  <= MUL;
              end
              default: begin
                result_q <= '0;
                err_q    <= 1'b1;
                state_q  <= DONE;
              end
            endcase
          end else begin
            state_q <= IDLE;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_d;
          if (last_iter_d) begin
            result_q <= acc_d;
            err_q    <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign err    = err_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == MUL);

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit: the driver pushes the arithmetic
// expectation of every accepted request, a monitor pops it on each done.
module tb_seq_arith_unit;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        op;
  logic [W-1:0]      A, B;
  logic [2*W-1:0]    result;
  logic              done, busy, err;

  logic              start8;
  logic [1:0]        op8;
  logic [W8-1:0]     A8, B8;
  logic [2*W8-1:0]   result8;
  logic              done8, busy8, err8;

  always #5 clk = ~clk;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .result(result), .done(done), .busy(busy), .err(err)
  );

  seq_arith_unit #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .A(A8), .B(B8),
    .result(result8), .done(done8), .busy(busy8), .err(err8)
  );

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ai;
    int   bi;
    ai    = int'(a);
    bi    = int'(b);
    e.err = 1'b0;
    case (o)
      2'd0: e.res = (2*W)'(ai + bi);
      2'd1: e.res = (ai >= bi) ? (2*W)'(ai - bi) : (2*W)'(ai - bi + 2 * (1 << W));
      2'd2: e.res = (2*W)'(ai * bi);
      default: begin
        e.res = '0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor: sample 2 time units after each rising edge.
  logic           mon_en = 1'b0;
  logic [2*W-1:0] last_res;
  logic           last_err;

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      mon_en   = 1'b1;
      last_res = '0;
      last_err = 1'b0;
      check("rst_result", 64'(result), 64'(0));
      check("rst_done",   64'(done),   64'(0));
      check("rst_busy",   64'(busy),   64'(0));
      check("rst_err",    64'(err),    64'(0));
    end else if (mon_en) begin
      if (done) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no completion at %0t", result, $time);
        end else begin
          e = sb_q.pop_front();
          check("sb_result", 64'(result), 64'(e.res));
          check("sb_err",    64'(err),    64'(e.err));
          last_res = e.res;
          last_err = e.err;
        end
      end else begin
        check("hold_result", 64'(result), 64'(last_res));
        check("hold_err",    64'(err),    64'(last_err));
      end
    end
  end

  // Issue one accepted request at the current negedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    op    = 2'($urandom);
  endtask

  // Wait (bounded) for done; optionally pulse an ignored start while busy.
  task automatic wait_done(input int exp_lat, input bit poke);
    int n  = 0;
    int nb = 0;
    while (!done && n < 50) begin
      if (busy) nb++;
      if (poke && n == 0) begin
        start = 1'b1;
        op    = 2'b00;
        A     = W'(1);
        B     = W'(1);
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done at %0d", n, exp_lat);
    end
    check("latency",     64'(n),  64'(exp_lat));
    check("busy_cycles", 64'(nb), 64'(exp_lat));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_done", 64'(done), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ro;
    int         n8;

    rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    start8 = 1'b0; op8 = 2'b00; A8 = '0; B8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("idle_result", 64'(result), 64'(0));

    // add with carry
    issue(2'b00, 4'd15, 4'd15);
    wait_done(0, 1'b0);
    check("add_15_15", 64'(result), 64'h1E);
    idle(1);
    check("add_hold", 64'(result), 64'h1E);

    // subtract both directions, back-to-back
    issue(2'b01, 4'd3, 4'd5);
    wait_done(0, 1'b0);
    check("sub_3_5", 64'(result), 64'h1E);
    issue(2'b01, 4'd9, 4'd4);
    wait_done(0, 1'b0);
    check("sub_9_4", 64'(result), 64'h05);
    idle(1);

    // multiply with a start poked while busy
    issue(2'b10, 4'd15, 4'd15);
    wait_done(W, 1'b1);
    check("mul_15_15", 64'(result), 64'hE1);
    idle(1);
    issue(2'b10, 4'd0, 4'd13);
    wait_done(W, 1'b0);
    check("mul_0_13", 64'(result), 64'h00);
    issue(2'b10, 4'd13, 4'd1);
    wait_done(W, 1'b0);
    check("mul_13_1", 64'(result), 64'h0D);
    idle(1);

    // reserved op then a clean add
    issue(2'b11, 4'd6, 4'd7);
    wait_done(0, 1'b0);
    check("rsv_result", 64'(result), 64'h00);
    check("rsv_err",    64'(err),    64'(1));
    issue(2'b00, 4'd1, 4'd1);
    wait_done(0, 1'b0);
    check("add_after_rsv", 64'(result), 64'h02);
    check("err_cleared",   64'(err),    64'(0));
    idle(1);

    // abort a multiply at iteration 2 with reset
    start = 1'b1; op = 2'b10; A = 4'd7; B = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",   64'(busy),   64'(0));
    check("abort_done",   64'(done),   64'(0));
    check("abort_result", 64'(result), 64'(0));
    rst = 1'b0;
    idle(3);

    // 8-bit instance: 255*255 after 9 edges
    start8 = 1'b1; op8 = 2'b10; A8 = 8'd255; B8 = 8'd255;
    @(negedge clk);
    start8 = 1'b0; A8 = 8'd3; B8 = 8'd3;
    n8 = 1;
    while (!done8 && n8 < 50) begin
      @(negedge clk);
      n8++;
    end
    check("w8_latency", 64'(n8),      64'(9));
    check("w8_result",  64'(result8), 64'hFE01);
    check("w8_err",     64'(err8),    64'(0));

    // random traffic, mixed idle gaps and back-to-back accepts
    repeat (80) begin
      ro = 2'($urandom_range(0, 3));
      issue(ro, W'($urandom), W'($urandom));
      wait_done((ro == 2'b10) ? W : 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(3);
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
